biu_cache_arb: RTL and testbench
================================

Name: biu_cache_arb

Overview:
- Two-master line-request arbiter sitting directly upstream of the bus interface unit's cache request/response channel.
- Merges icache refill requests (master 0) and dcache refill/writeback requests (master 1) into one cache_req stream.
- Keeps one transaction outstanding, tags its owner, and routes the 512-bit response back to that master only.

Parameters:
ADDR_W, 64, request address width
LINE_W, 512, cache line data width
OFFS_W, 6, line offset bits forced to zero on the downstream address
PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority to dcache (master 1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ic_req_vld_i  in  1  icache request valid (read only)
ic_req_rdy_o  out  1  icache request accepted
ic_req_addr_i  in  ADDR_W  icache line address
ic_resp_vld_o  out  1  icache response valid
ic_resp_rdy_i  in  1  icache response ready
ic_resp_rdata_o  out  LINE_W  icache line data
ic_resp_err_o  out  1  icache bus error
dc_req_vld_i  in  1  dcache request valid
dc_req_rdy_o  out  1  dcache request accepted
dc_req_rd_i  in  1  1 = refill read, 0 = writeback
dc_req_addr_i  in  ADDR_W  dcache line address
dc_req_wdata_i  in  LINE_W  writeback data
dc_resp_vld_o  out  1  dcache response valid
dc_resp_rdy_i  in  1  dcache response ready
dc_resp_rdata_o  out  LINE_W  dcache line data
dc_resp_err_o  out  1  dcache bus error
cache_req_vld_o  out  1  request to BIU valid
cache_req_rdy_i  in  1  BIU request ready
cache_req_rd_o  out  1  read/write to BIU
cache_req_addr_o  out  ADDR_W  line-aligned address to BIU
cache_req_wdata_o  out  LINE_W  write data to BIU
cache_resp_vld_i  in  1  BIU response valid
cache_resp_rdy_o  out  1  response ready to BIU
cache_resp_rdata_i  in  LINE_W  BIU response data
cache_resp_err_i  in  1  BIU response error

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Handshake: valid/ready on every channel; a transfer occurs when both are high in the same cycle.
  - Masters hold vld and payload stable until rdy.
  - Arbiter holds cache_req_* stable until cache_req_rdy_i.
  - Arbiter holds *_resp_* stable until the owner's resp_rdy.
- Reset values:
  - all vld/rdy outputs 0
  - data/addr/err outputs 0
  - state = IDLE
  - owner = 0
  - last_grant = 1 (so the icache wins the first tie)
- FSM states: IDLE, ISSUE, WAIT, DELIVER.
- IDLE:
  - {ic,dc}_req_rdy_o are combinational grant outputs: at most one high, and only if that master's vld is high.
  - Grant rule when both valid:
    - PRIO_MODE=0: the master not equal to last_grant.
    - PRIO_MODE=1: dcache.
  - Single valid: grant that master.
  - On grant (cycle T), latch:
    - rd (icache always 1)
    - addr with low OFFS_W bits zeroed
    - wdata (icache: 0)
    - owner; last_grant := owner
  - Go to ISSUE.
- ISSUE: cache_req_vld_o=1 from T+1. On cache_req_rdy_i, drop vld next cycle and go to WAIT.
- WAIT: cache_resp_rdy_o=1 (registered, asserted on WAIT entry). On cache_resp_vld_i, capture rdata/err, deassert cache_resp_rdy_o, go to DELIVER.
- DELIVER:
  - Owner's resp_vld_o=1 one cycle after capture; the other master's resp_vld stays 0 and its data is 0.
  - On the owner's resp_rdy, deassert and return to IDLE.
  - A new grant is possible in the cycle after return (no same-cycle bypass).
- Writeback responses: data is forwarded as received; the dcache ignores it; err is valid.
- The arbiter never asserts any req_rdy outside IDLE; back-to-back requests stall.
- cache_resp_vld_i outside WAIT is ignored (rdy=0). It is illegal by protocol; an optional assertion flags it.
- Master dropping vld before grant is legal: no grant, no state change.
- Reset mid-operation: return immediately to reset values. The in-flight transaction is abandoned; the BIU is reset on the same rst_n.

Decomposition:
- Shared package biu_pkg:
  - ADDR_W/LINE_W/OFFS_W constants
  - arb state encoding (2-bit)
  - master id constants MID_IC=0, MID_DC=1
- One sub-module, biu_arb_rr2: two-input grant logic plus last_grant register, PRIO_MODE-aware.
- FSM and payload registers stay in biu_cache_arb.

Test Plan:
- Icache only: addr 0x8000_0047 -> cache_req_addr_o=0x8000_0040, rd=1, vld one cycle after grant; BIU returns 0xA5.. -> ic_resp_rdata_o=0xA5.., dc_resp_vld_o stays 0.
- Simultaneous icache+dcache valid after reset, PRIO_MODE=0 -> icache granted first, dcache second; repeated ties alternate ic, dc, ic, dc.
- PRIO_MODE=1, both valid continuously for 3 requests -> dcache granted every time while valid; icache starves until dc_req_vld_i=0.
- Dcache writeback, wdata=line of 0x1111.., cache_req_rdy_i delayed 5 cycles -> cache_req_* stable all 5 cycles; response err=1 -> dc_resp_err_o=1.
- Owner backpressure: dc_resp_rdy_i low 4 cycles with icache valid -> dc_resp stable, ic_req_rdy_o stays 0 until cycle after dc accept.
- rst_n asserted during WAIT -> all outputs 0 asynchronously; next icache request is handled normally from IDLE.

Source files
------------

// File: rtl/biu_pkg.sv
// Shared definitions for the BIU cache request arbiter.
// Provides the default bus widths, the 2-bit arbiter state encoding and the master ids.
package biu_pkg;

  localparam int unsigned BIU_ADDR_W = 64;
  localparam int unsigned BIU_LINE_W = 512;
  localparam int unsigned BIU_OFFS_W = 6;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StWait    = 2'd2,
    StDeliver = 2'd3
  } arb_state_e;

  localparam logic MID_IC = 1'b0;
  localparam logic MID_DC = 1'b1;

endpackage

// File: rtl/biu_cache_arb_if.sv
// Bundle of all handshake channels around the cache arbiter.
//   ic_req_* / ic_resp_* : icache line request (read only) and response
//   dc_req_* / dc_resp_* : dcache refill/writeback request and response
//   cache_req_* / cache_resp_* : merged stream towards the BIU
// Modports: slave = arbiter view, master = environment (caches + BIU) view.
interface biu_cache_arb_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned LINE_W = 512
);

  logic              ic_req_vld_i;
  logic              ic_req_rdy_o;
  logic [ADDR_W-1:0] ic_req_addr_i;
  logic              ic_resp_vld_o;
  logic              ic_resp_rdy_i;
  logic [LINE_W-1:0] ic_resp_rdata_o;
  logic              ic_resp_err_o;

  logic              dc_req_vld_i;
  logic              dc_req_rdy_o;
  logic              dc_req_rd_i;
  logic [ADDR_W-1:0] dc_req_addr_i;
  logic [LINE_W-1:0] dc_req_wdata_i;
  logic              dc_resp_vld_o;
  logic              dc_resp_rdy_i;
  logic [LINE_W-1:0] dc_resp_rdata_o;
  logic              dc_resp_err_o;

  logic              cache_req_vld_o;
  logic              cache_req_rdy_i;
  logic              cache_req_rd_o;
  logic [ADDR_W-1:0] cache_req_addr_o;
  logic [LINE_W-1:0] cache_req_wdata_o;
  logic              cache_resp_vld_i;
  logic              cache_resp_rdy_o;
  logic [LINE_W-1:0] cache_resp_rdata_i;
  logic              cache_resp_err_i;

  modport slave (
    input  ic_req_vld_i, ic_req_addr_i, ic_resp_rdy_i,
    input  dc_req_vld_i, dc_req_rd_i, dc_req_addr_i, dc_req_wdata_i, dc_resp_rdy_i,
    input  cache_req_rdy_i, cache_resp_vld_i, cache_resp_rdata_i, cache_resp_err_i,
    output ic_req_rdy_o, ic_resp_vld_o, ic_resp_rdata_o, ic_resp_err_o,
    output dc_req_rdy_o, dc_resp_vld_o, dc_resp_rdata_o, dc_resp_err_o,
    output cache_req_vld_o, cache_req_rd_o, cache_req_addr_o, cache_req_wdata_o,
    output cache_resp_rdy_o
  );

  modport master (
    output ic_req_vld_i, ic_req_addr_i, ic_resp_rdy_i,
    output dc_req_vld_i, dc_req_rd_i, dc_req_addr_i, dc_req_wdata_i, dc_resp_rdy_i,
    output cache_req_rdy_i, cache_resp_vld_i, cache_resp_rdata_i, cache_resp_err_i,
    input  ic_req_rdy_o, ic_resp_vld_o, ic_resp_rdata_o, ic_resp_err_o,
    input  dc_req_rdy_o, dc_resp_vld_o, dc_resp_rdata_o, dc_resp_err_o,
    input  cache_req_vld_o, cache_req_rd_o, cache_req_addr_o, cache_req_wdata_o,
    input  cache_resp_rdy_o
  );

endinterface

// File: rtl/biu_arb_rr2.sv
// Two-input grant logic with a last-grant register.
//   en            : grants allowed this cycle (arbiter idle)
//   ic_vld/dc_vld : request valids of master 0 / master 1
//   ic_gnt/dc_gnt : one-hot (or zero) combinational grants
//   gnt_id        : id of the granted master (valid when a grant is high)
// PRIO_MODE 0 = round-robin on ties, 1 = dcache always wins ties.
module biu_arb_rr2
  import biu_pkg::*;
#(
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic ic_vld,
  input  logic dc_vld,
  output logic ic_gnt,
  output logic dc_gnt,
  output logic gnt_id
);

  logic last_q, last_d;

  always_comb begin
    ic_gnt = 1'b0;
    dc_gnt = 1'b0;
    if (en) begin
      if (ic_vld && dc_vld) begin
        // Tie: fixed priority to dcache, or the master that did not win last time.
        if ((PRIO_MODE == 1) || (last_q == MID_IC)) begin
          dc_gnt = 1'b1;
        end else begin
          ic_gnt = 1'b1;
        end
      end else begin
        ic_gnt = ic_vld;
        dc_gnt = dc_vld;
      end
    end
  end

  assign gnt_id = dc_gnt ? MID_DC : MID_IC;

  always_comb begin
    last_d = last_q;
    if (ic_gnt || dc_gnt) begin
      last_d = gnt_id;
    end
  end

  // Reset to dcache so the icache wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= MID_DC;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/biu_cache_arb.sv
// Two-master line-request arbiter in front of the BIU cache channel.
// Merges icache (master 0) and dcache (master 1) requests into one cache_req stream,
// keeps a single transaction outstanding and returns the response to its owner only.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : all request/response channels (slave modport)
module biu_cache_arb
  import biu_pkg::*;
#(
  parameter int unsigned ADDR_W    = BIU_ADDR_W,
  parameter int unsigned LINE_W    = BIU_LINE_W,
  parameter int unsigned OFFS_W    = BIU_OFFS_W,
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  biu_cache_arb_if.slave        bus
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              req_vld_q, req_vld_d;
  logic              resp_rdy_q, resp_rdy_d;
  logic [LINE_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              ic_resp_vld_q, ic_resp_vld_d;
  logic              dc_resp_vld_q, dc_resp_vld_d;

  logic ic_gnt, dc_gnt, gnt_id;
  logic owner_rdy;

  biu_arb_rr2 #(
    .PRIO_MODE (PRIO_MODE)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state_q == StIdle),
    .ic_vld (bus.ic_req_vld_i),
    .dc_vld (bus.dc_req_vld_i),
    .ic_gnt (ic_gnt),
    .dc_gnt (dc_gnt),
    .gnt_id (gnt_id)
  );

  assign owner_rdy = (owner_q == MID_DC) ? bus.dc_resp_rdy_i : bus.ic_resp_rdy_i;

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    rd_d          = rd_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    req_vld_d     = req_vld_q;
    resp_rdy_d    = resp_rdy_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    ic_resp_vld_d = ic_resp_vld_q;
    dc_resp_vld_d = dc_resp_vld_q;

    unique case (state_q)
      StIdle: begin
        if (ic_gnt || dc_gnt) begin
          owner_d = gnt_id;
          if (dc_gnt) begin
            rd_d    = bus.dc_req_rd_i;
            addr_d  = {bus.dc_req_addr_i[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
            wdata_d = bus.dc_req_wdata_i;
          end else begin
            rd_d    = 1'b1;
            addr_d  = {bus.ic_req_addr_i[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
            wdata_d = '0;
          end
          req_vld_d = 1'b1;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        if (bus.cache_req_rdy_i) begin
          req_vld_d  = 1'b0;
          resp_rdy_d = 1'b1;
          state_d    = StWait;
        end
      end
      StWait: begin
        if (bus.cache_resp_vld_i) begin
          rdata_d    = bus.cache_resp_rdata_i;
          err_d      = bus.cache_resp_err_i;
          resp_rdy_d = 1'b0;
          if (owner_q == MID_DC) begin
            dc_resp_vld_d = 1'b1;
          end else begin
            ic_resp_vld_d = 1'b1;
          end
          state_d = StDeliver;
        end
      end
      StDeliver: begin
        if (owner_rdy) begin
          ic_resp_vld_d = 1'b0;
          dc_resp_vld_d = 1'b0;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      owner_q       <= MID_IC;
      rd_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      req_vld_q     <= 1'b0;
      resp_rdy_q    <= 1'b0;
      rdata_q       <= '0;
      err_q         <= 1'b0;
      ic_resp_vld_q <= 1'b0;
      dc_resp_vld_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      rd_q          <= rd_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      req_vld_q     <= req_vld_d;
      resp_rdy_q    <= resp_rdy_d;
      rdata_q       <= rdata_d;
      err_q         <= err_d;
      ic_resp_vld_q <= ic_resp_vld_d;
      dc_resp_vld_q <= dc_resp_vld_d;
    end
  end

  assign bus.ic_req_rdy_o      = ic_gnt;
  assign bus.dc_req_rdy_o      = dc_gnt;

  assign bus.cache_req_vld_o   = req_vld_q;
  assign bus.cache_req_rd_o    = rd_q;
  assign bus.cache_req_addr_o  = addr_q;
  assign bus.cache_req_wdata_o = wdata_q;
  assign bus.cache_resp_rdy_o  = resp_rdy_q;

  // Response data is gated by the owner's valid so the non-owner always sees zero.
  assign bus.ic_resp_vld_o     = ic_resp_vld_q;
  assign bus.ic_resp_rdata_o   = ic_resp_vld_q ? rdata_q : '0;
  assign bus.ic_resp_err_o     = ic_resp_vld_q & err_q;
  assign bus.dc_resp_vld_o     = dc_resp_vld_q;
  assign bus.dc_resp_rdata_o   = dc_resp_vld_q ? rdata_q : '0;
  assign bus.dc_resp_err_o     = dc_resp_vld_q & err_q;

endmodule

// File: tb/tb_biu_cache_arb.sv
// Directed bench for biu_cache_arb: a round-robin instance and a dcache-priority instance
// run in lockstep on the same stimulus; sel picks which one is checked.
module tb_biu_cache_arb;
  import biu_pkg::*;

  localparam int unsigned AW = 64;
  localparam int unsigned LW = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic          ic_vld = 0, dc_vld = 0, dc_rd = 0, ic_rrdy = 0, dc_rrdy = 0;
  logic          c_req_rdy = 0, c_resp_vld = 0, c_resp_err = 0;
  logic [AW-1:0] ic_addr = '0, dc_addr = '0;
  logic [LW-1:0] dc_wdata = '0, c_rdata = '0;
  logic          sel = 1'b0;

  biu_cache_arb_if #(.ADDR_W(AW), .LINE_W(LW)) if_rr ();
  biu_cache_arb_if #(.ADDR_W(AW), .LINE_W(LW)) if_fp ();

  assign if_rr.ic_req_vld_i = ic_vld;        assign if_fp.ic_req_vld_i = ic_vld;
  assign if_rr.ic_req_addr_i = ic_addr;      assign if_fp.ic_req_addr_i = ic_addr;
  assign if_rr.ic_resp_rdy_i = ic_rrdy;      assign if_fp.ic_resp_rdy_i = ic_rrdy;
  assign if_rr.dc_req_vld_i = dc_vld;        assign if_fp.dc_req_vld_i = dc_vld;
  assign if_rr.dc_req_rd_i = dc_rd;          assign if_fp.dc_req_rd_i = dc_rd;
  assign if_rr.dc_req_addr_i = dc_addr;      assign if_fp.dc_req_addr_i = dc_addr;
  assign if_rr.dc_req_wdata_i = dc_wdata;    assign if_fp.dc_req_wdata_i = dc_wdata;
  assign if_rr.dc_resp_rdy_i = dc_rrdy;      assign if_fp.dc_resp_rdy_i = dc_rrdy;
  assign if_rr.cache_req_rdy_i = c_req_rdy;  assign if_fp.cache_req_rdy_i = c_req_rdy;
  assign if_rr.cache_resp_vld_i = c_resp_vld; assign if_fp.cache_resp_vld_i = c_resp_vld;
  assign if_rr.cache_resp_rdata_i = c_rdata; assign if_fp.cache_resp_rdata_i = c_rdata;
  assign if_rr.cache_resp_err_i = c_resp_err; assign if_fp.cache_resp_err_i = c_resp_err;

  logic          o_ic_req_rdy, o_dc_req_rdy, o_req_vld, o_req_rd, o_resp_rdy;
  logic          o_ic_resp_vld, o_ic_err, o_dc_resp_vld, o_dc_err;
  logic [AW-1:0] o_req_addr;
  logic [LW-1:0] o_req_wdata, o_ic_rdata, o_dc_rdata;

  assign o_ic_req_rdy  = sel ? if_fp.ic_req_rdy_o      : if_rr.ic_req_rdy_o;
  assign o_dc_req_rdy  = sel ? if_fp.dc_req_rdy_o      : if_rr.dc_req_rdy_o;
  assign o_req_vld     = sel ? if_fp.cache_req_vld_o   : if_rr.cache_req_vld_o;
  assign o_req_rd      = sel ? if_fp.cache_req_rd_o    : if_rr.cache_req_rd_o;
  assign o_req_addr    = sel ? if_fp.cache_req_addr_o  : if_rr.cache_req_addr_o;
  assign o_req_wdata   = sel ? if_fp.cache_req_wdata_o : if_rr.cache_req_wdata_o;
  assign o_resp_rdy    = sel ? if_fp.cache_resp_rdy_o  : if_rr.cache_resp_rdy_o;
  assign o_ic_resp_vld = sel ? if_fp.ic_resp_vld_o     : if_rr.ic_resp_vld_o;
  assign o_ic_rdata    = sel ? if_fp.ic_resp_rdata_o   : if_rr.ic_resp_rdata_o;
  assign o_ic_err      = sel ? if_fp.ic_resp_err_o     : if_rr.ic_resp_err_o;
  assign o_dc_resp_vld = sel ? if_fp.dc_resp_vld_o     : if_rr.dc_resp_vld_o;
  assign o_dc_rdata    = sel ? if_fp.dc_resp_rdata_o   : if_rr.dc_resp_rdata_o;
  assign o_dc_err      = sel ? if_fp.dc_resp_err_o     : if_rr.dc_resp_err_o;

  biu_cache_arb #(.ADDR_W(AW), .LINE_W(LW), .OFFS_W(6), .PRIO_MODE(0)) u_dut_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_rr)
  );

  biu_cache_arb #(.ADDR_W(AW), .LINE_W(LW), .OFFS_W(6), .PRIO_MODE(1)) u_dut_fp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_fp)
  );

  typedef struct {
    logic          ic_v;
    logic          dc_v;
    logic          dc_rd;
    logic [AW-1:0] ic_addr;
    logic [AW-1:0] dc_addr;
    logic [LW-1:0] wdata;
    logic          exp_dc;
    logic          exp_rd;
    logic [AW-1:0] exp_addr;
    logic [LW-1:0] exp_wdata;
    int            delay;
    logic [LW-1:0] rdata;
    logic          err;
  } vec_t;

  vec_t tbl [6];

  function automatic vec_t mk(input logic ic_v, input logic dc_v, input logic rd,
                              input logic [AW-1:0] ia, input logic [AW-1:0] da,
                              input logic [LW-1:0] wd, input logic edc, input logic erd,
                              input logic [AW-1:0] ea, input logic [LW-1:0] ewd,
                              input int dly, input logic [LW-1:0] rdat, input logic er);
    vec_t v;
    v.ic_v = ic_v; v.dc_v = dc_v; v.dc_rd = rd; v.ic_addr = ia; v.dc_addr = da;
    v.wdata = wd; v.exp_dc = edc; v.exp_rd = erd; v.exp_addr = ea; v.exp_wdata = ewd;
    v.delay = dly; v.rdata = rdat; v.err = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts at a negedge with the arbiter idle; ends one negedge after the grant edge.
  task automatic do_grant(input logic ic_v, input logic dc_v, input logic rd,
                          input logic [AW-1:0] ia, input logic [AW-1:0] da,
                          input logic [LW-1:0] wd, input logic exp_dc);
    ic_vld = ic_v; dc_vld = dc_v; dc_rd = rd; ic_addr = ia; dc_addr = da; dc_wdata = wd;
    #1;
    chk("ic_req_rdy_grant", o_ic_req_rdy, !exp_dc);
    chk("dc_req_rdy_grant", o_dc_req_rdy, exp_dc);
    chk("req_vld_before_issue", o_req_vld, 0);
    @(negedge clk);
    // The granted master is done; scramble its payload to prove it was latched.
    if (exp_dc) begin
      dc_vld = 0; dc_addr = '1; dc_wdata = '1; dc_rd = ~rd;
    end else begin
      ic_vld = 0; ic_addr = '1;
    end
  endtask

  task automatic do_issue(input logic exp_rd, input logic [AW-1:0] exp_addr,
                          input logic [LW-1:0] exp_wdata, input int delay);
    #1;
    chk("req_vld", o_req_vld, 1);
    chk("req_rd", o_req_rd, exp_rd);
    chk("req_addr", o_req_addr, exp_addr);
    chk("req_wdata", o_req_wdata, exp_wdata);
    chk("no_rdy_in_issue", {o_ic_req_rdy, o_dc_req_rdy}, 0);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      #1;
      chk("req_hold_vld", o_req_vld, 1);
      chk("req_hold_rd", o_req_rd, exp_rd);
      chk("req_hold_addr", o_req_addr, exp_addr);
      chk("req_hold_wdata", o_req_wdata, exp_wdata);
    end
    c_req_rdy = 1;
    @(negedge clk);
    c_req_rdy = 0;
    #1;
    chk("req_vld_dropped", o_req_vld, 0);
    chk("resp_rdy_in_wait", o_resp_rdy, 1);
  endtask

  task automatic do_resp(input logic [LW-1:0] rdata, input logic err, input logic exp_dc,
                         input int bp, input logic ic_hold);
    c_resp_vld = 1; c_rdata = rdata; c_resp_err = err;
    @(negedge clk);
    c_resp_vld = 0; c_rdata = '0; c_resp_err = 0;
    #1;
    chk("resp_rdy_dropped", o_resp_rdy, 0);
    chk("owner_resp_vld", exp_dc ? o_dc_resp_vld : o_ic_resp_vld, 1);
    chk("owner_rdata", exp_dc ? o_dc_rdata : o_ic_rdata, rdata);
    chk("owner_err", exp_dc ? o_dc_err : o_ic_err, err);
    chk("other_resp_vld", exp_dc ? o_ic_resp_vld : o_dc_resp_vld, 0);
    chk("other_rdata", exp_dc ? o_ic_rdata : o_dc_rdata, '0);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      #1;
      chk("bp_owner_vld", exp_dc ? o_dc_resp_vld : o_ic_resp_vld, 1);
      chk("bp_owner_rdata", exp_dc ? o_dc_rdata : o_ic_rdata, rdata);
      if (ic_hold) chk("bp_ic_req_rdy", o_ic_req_rdy, 0);
    end
    if (exp_dc) dc_rrdy = 1; else ic_rrdy = 1;
    #1;
    chk("no_rdy_in_deliver", {o_ic_req_rdy, o_dc_req_rdy}, 0);
    @(negedge clk);
    dc_rrdy = 0; ic_rrdy = 0;
    #1;
    chk("owner_vld_dropped", exp_dc ? o_dc_resp_vld : o_ic_resp_vld, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = mk(1, 1, 1, 64'h0000_1000_0000_0010, 64'h0000_2000_0000_00FF, '0,
                0, 1, 64'h0000_1000_0000_0000, '0, 0, {16{32'h0123_4567}}, 0);
    tbl[1] = mk(0, 1, 1, '0, 64'h0000_2000_0000_00FF, '0,
                1, 1, 64'h0000_2000_0000_00C0, '0, 1, {16{32'h89AB_CDEF}}, 0);
    tbl[2] = mk(1, 1, 1, 64'h0000_0000_0000_7FC5, 64'h1234_5678_9ABC_DEF7, '0,
                0, 1, 64'h0000_0000_0000_7FC0, '0, 0, {64{8'h3C}}, 0);
    tbl[3] = mk(1, 1, 1, 64'h0000_0000_8000_0047, 64'h1234_5678_9ABC_DEF7, '0,
                1, 1, 64'h1234_5678_9ABC_DEC0, '0, 0, {64{8'h5A}}, 0);
    tbl[4] = mk(1, 0, 0, 64'h0000_0000_8000_0047, '0, '0,
                0, 1, 64'h0000_0000_8000_0040, '0, 0, {64{8'hA5}}, 0);
    tbl[5] = mk(0, 1, 0, '0, 64'h0000_0000_3000_0005, {32{16'h1111}},
                1, 0, 64'h0000_0000_3000_0000, {32{16'h1111}}, 5, {64{8'hEE}}, 1);

    // Reset state.
    #1;
    chk("rst_req_vld", o_req_vld, 0);
    chk("rst_resp_rdy", o_resp_rdy, 0);
    chk("rst_req_addr", o_req_addr, '0);
    chk("rst_resp_vld", {o_ic_resp_vld, o_dc_resp_vld}, 0);
    chk("rst_req_rdy", {o_ic_req_rdy, o_dc_req_rdy}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Table: tie alternation ic/dc/ic/dc, icache-only, delayed writeback with error.
    for (int k = 0; k < 6; k++) begin
      do_grant(tbl[k].ic_v, tbl[k].dc_v, tbl[k].dc_rd, tbl[k].ic_addr, tbl[k].dc_addr,
               tbl[k].wdata, tbl[k].exp_dc);
      do_issue(tbl[k].exp_rd, tbl[k].exp_addr, tbl[k].exp_wdata, tbl[k].delay);
      do_resp(tbl[k].rdata, tbl[k].err, tbl[k].exp_dc, 0, 0);
    end

    // Owner backpressure while the icache waits.
    do_grant(0, 1, 1, '0, 64'h0000_0000_4000_0080, '0, 1);
    do_issue(1, 64'h0000_0000_4000_0080, '0, 0);
    ic_vld = 1; ic_addr = 64'h0000_0000_9000_00FF;
    do_resp({16{32'hDEAD_BEEF}}, 0, 1, 4, 1);
    do_grant(1, 0, 1, 64'h0000_0000_9000_00FF, '0, '0, 0);
    do_issue(1, 64'h0000_0000_9000_00C0, '0, 0);
    do_resp({16{32'hCAFE_F00D}}, 0, 0, 0, 0);

    // Reset while waiting for the BIU response.
    do_grant(1, 0, 1, 64'h0000_0000_5000_0041, '0, '0, 0);
    #1;
    chk("mid_req_vld", o_req_vld, 1);
    c_req_rdy = 1;
    @(negedge clk);
    c_req_rdy = 0;
    #1;
    chk("mid_in_wait", o_resp_rdy, 1);
    #1;
    rst_n = 0;
    #1;
    chk("arst_resp_rdy", o_resp_rdy, 0);
    chk("arst_req_rd", o_req_rd, 0);
    chk("arst_req_addr", o_req_addr, '0);
    chk("arst_req_vld", o_req_vld, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    do_grant(1, 0, 1, 64'h0000_0000_6000_0013, '0, '0, 0);
    do_issue(1, 64'h0000_0000_6000_0000, '0, 0);
    do_resp({64{8'h77}}, 0, 0, 0, 0);

    // Fixed priority: dcache wins every tie while valid, icache waits.
    sel = 1;
    for (int i = 0; i < 3; i++) begin
      do_grant(1, 1, 1, 64'h0000_0000_7000_0001, 64'h0000_0000_7100_0041 + 64'(i * 64), '0, 1);
      do_issue(1, 64'h0000_0000_7100_0040 + 64'(i * 64), '0, 0);
      do_resp({64{8'h10 + 8'(i)}}, 0, 1, 0, 0);
    end
    do_grant(1, 0, 1, 64'h0000_0000_7000_0001, '0, '0, 0);
    do_issue(1, 64'h0000_0000_7000_0000, '0, 0);
    do_resp({64{8'h99}}, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
